// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported, fixed-latency unified memory between instruction fetch and load/store.
// One access is in flight at a time. Completion is signalled by a registered one-cycle ready pulse.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_fetch,
    output logic              stall_pipe
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {SRC_FETCH, SRC_DATA} src_t;

    state_t            state, state_nxt;
    src_t              owner, last_grant;
    logic [CNT_W-1:0]  cnt;
    logic              d_req;
    logic              fetch_cand, data_cand;
    logic              grant_fetch, grant_data, grant;
    logic              capture;

    assign d_req       = d_rd | d_wr;
    assign stall_fetch = if_req & ~if_ready;
    assign stall_pipe  = d_req & ~d_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // In DONE the finishing requester still holds its (stale) request, so only the other side may win.
    always_comb begin
        state_nxt  = state;
        fetch_cand = 1'b0;
        data_cand  = 1'b0;
        case (state)
            IDLE: begin
                fetch_cand = if_req;
                data_cand  = d_req;
            end
            DONE: begin
                fetch_cand = if_req && (owner != SRC_FETCH);
                data_cand  = d_req && (owner != SRC_DATA);
            end
            default: ;
        endcase

        grant_fetch = fetch_cand && (!data_cand || last_grant == SRC_DATA);
        grant_data  = data_cand && (!fetch_cand || last_grant == SRC_FETCH);
        grant       = grant_fetch || grant_data;
        capture     = (state == ACCESS) && !mem_en && (cnt == CNT_W'(1));

        case (state)
            IDLE:    if (grant) state_nxt = ACCESS;
            ACCESS:  if (capture) state_nxt = DONE;
            DONE:    state_nxt = grant ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            cnt        <= '0;
            owner      <= SRC_FETCH;
            last_grant <= SRC_DATA;
        end else begin
            mem_en   <= grant;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;

            // The counter holds during the strobe cycle, so it reaches 1 exactly when mem_rdata is valid.
            if (grant) begin
                mem_addr   <= grant_data ? d_addr : if_addr;
                mem_wdata  <= d_wdata;
                mem_we     <= grant_data & d_wr;
                owner      <= grant_data ? SRC_DATA : SRC_FETCH;
                last_grant <= grant_data ? SRC_DATA : SRC_FETCH;
                cnt        <= CNT_W'(MEM_LAT);
            end else if (state == ACCESS && !mem_en) begin
                cnt <= cnt - 1'b1;
            end

            if (capture) begin
                if (owner == SRC_FETCH) begin
                    if_rdata <= mem_rdata;
                    if_ready <= 1'b1;
                end else begin
                    if (!mem_we) d_rdata <= mem_rdata;
                    d_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Time-multiplexes one single-ported, fixed-latency unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined RISC-V core. Grants one access at a time and drives the memory port from registers. Returns read data through a ready handshake. Generates the stall signals the hazard logic uses to freeze the PC/IF-ID registers and the whole pipeline.

Parameters:
ADDR_W, 32, byte address width of both requesters and the memory port
DATA_W, 32, word width
MEM_LAT, 1, cycles from the memory enable cycle to valid mem_rdata; legal range 1..4

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held until if_ready
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction; valid while if_ready=1
if_ready  out  1  one-cycle fetch completion
d_rd  in  1  load request (MemRead); held until d_ready
d_wr  in  1  store request (MemWrite); held until d_ready
d_addr  in  ADDR_W  data address (ALU result)
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data; valid while d_ready=1
d_ready  out  1  one-cycle data completion
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  write enable; qualified by mem_en
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
stall_fetch  out  1  if_req & ~if_ready (combinational)
stall_pipe  out  1  (d_rd|d_wr) & ~d_ready (combinational)

Behaviour:
- FSM states: IDLE, ACCESS, DONE. Owner register: FETCH or DATA. last_grant register: FETCH or DATA.
- Reset (async, immediate): state IDLE. mem_en, mem_we, if_ready, d_ready = 0. mem_addr, mem_wdata, if_rdata, d_rdata = 0. Down-counter = 0. last_grant = DATA, so fetch wins the first tie.
- IDLE, arbitration in cycle T:
  - Only one requester active: grant it.
  - Both active: grant the one not equal to last_grant (round-robin).
  - No request: stay in IDLE.
  - On grant: load mem_addr, mem_wdata and mem_we (=d_wr for DATA, 0 for FETCH). Set owner and last_grant. Load counter = MEM_LAT. Go to ACCESS.
- ACCESS:
  - mem_en=1 only in the first ACCESS cycle (T+1).
  - Counter decrements every ACCESS cycle after the first.
  - In the cycle where mem_rdata is valid (T+1+MEM_LAT), capture mem_rdata into if_rdata or d_rdata according to owner; go to DONE.
  - Stores do not update d_rdata.
- DONE (cycle T+2+MEM_LAT):
  - Assert owner's ready for exactly this cycle.
  - The completing requester's request is ignored this cycle (it is stale).
  - If the other requester is active, grant it in this cycle exactly as in IDLE (back-to-back, no dead cycle) and go to ACCESS. Otherwise go to IDLE.
- Request-to-ready latency = MEM_LAT+2 cycles. Peak throughput = one access per MEM_LAT+2 cycles.
- d_rd and d_wr both high: treat as a store.
- Address and data inputs are sampled only at grant. Changing them mid-access has no effect.
- A requester dropping its request before ready: the access still completes and ready still pulses; the requester ignores it.
- Ready outputs and rdata are registered. Stall outputs are combinational, so the pipeline unfreezes in the ready cycle.
- Reset mid-access: return to IDLE immediately. Any in-flight memory response is discarded. No ready pulse.
- No buffering: at most one outstanding access.

Test Plan:
- Fetch only, MEM_LAT=1: if_req=1, if_addr=0x10 at cycle 0, memory word 0x00500093 -> mem_en=1/mem_we=0/mem_addr=0x10 in cycle 1; if_ready=1, if_rdata=0x00500093 in cycle 3 only; stall_fetch=1 in cycles 0-2, 0 in cycle 3.
- Store: d_wr=1, d_addr=0x200, d_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF in cycle 1; d_ready in cycle 3; d_rdata unchanged; follow-up load of 0x200 returns 0xDEADBEEF.
- Tie after reset: if_req and d_rd both high at cycle 0 -> FETCH granted (mem_addr=if_addr cycle 1). In the fetch DONE cycle 3, DATA is granted (mem_en cycle 4), d_ready in cycle 6; stall_pipe=1 in cycles 0-5.
- Continuous requests from both for 30 cycles -> grants strictly alternate; no requester waits more than 2*(MEM_LAT+2) cycles.
- MEM_LAT=3 load -> mem_en in cycle 1, capture at end of cycle 4, d_ready in cycle 5.
- Assert rst during ACCESS cycle 2 of a load -> mem_en=0 and d_ready=0 immediately, no ready pulse after release; next request behaves like the first scenario.
